// File: rtl/vga_pattern_source_if.sv
// Pixel stream bundle between the pattern source and a VGA sink.
// The source drives pixel data and qualifiers, and the sink drives ready back.
interface vga_pattern_source_if;
  logic [11:0] data;
  logic        valid;
  logic        last;
  logic        frame_start;
  logic        ready;

  modport master (
    output data,
    output valid,
    output last,
    output frame_start,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    input  frame_start,
    output ready
  );
endinterface

// File: rtl/vga_pattern_source.sv
// Streams registered test-pattern pixels (bars, checker, grey ramp, moving bar)
// to a VGA sink under valid/ready flow control, one frame at a time.
module vga_pattern_source #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  vga_pattern_source_if.master  bus,
  output logic [7:0]            frame_count
);

  // Counters are at least wide enough for the x[9:4] and y[5] pattern taps.
  localparam int XW = ($clog2(H_ACTIVE) > 10) ? $clog2(H_ACTIVE) : 10;
  localparam int YW = ($clog2(V_ACTIVE) > 6) ? $clog2(V_ACTIVE) : 6;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic ONE_PIXEL_LINE = (H_ACTIVE == 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]    state;
  logic          armed;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    pat;
  logic [11:0]   data_q;
  logic          valid_q;
  logic          last_q;
  logic          frame_start_q;

  logic          xfer;
  logic          end_line;
  logic          end_frame;
  logic [XW-1:0] x_inc;
  logic [YW-1:0] y_inc;
  logic [7:0]    fc_inc;

  function automatic logic [11:0] pixel(input logic [XW-1:0] px,
                                        input logic          py5,
                                        input logic [1:0]    p,
                                        input logic [5:0]    fc);
    logic [2:0]  bar;
    logic [11:0] c;
    bar = 3'((32'(px) * 32'd8) / 32'(H_ACTIVE));
    c   = 12'h000;
    case (p)
      2'd0: begin
        case (bar)
          3'd0:    c = 12'hFFF;
          3'd1:    c = 12'hFF0;
          3'd2:    c = 12'h0FF;
          3'd3:    c = 12'h0F0;
          3'd4:    c = 12'hF0F;
          3'd5:    c = 12'hF00;
          3'd6:    c = 12'h00F;
          default: c = 12'h000;
        endcase
      end
      2'd1:    c = (px[5] ^ py5) ? 12'hFFF : 12'h000;
      2'd2:    c = {px[8:5], px[8:5], px[8:5]};
      default: c = (px[9:4] == fc) ? 12'hF00 : 12'h00F;
    endcase
    return c;
  endfunction

  always_comb begin
    xfer      = valid_q & bus.ready;
    end_line  = (x == X_LAST);
    end_frame = end_line && (y == Y_LAST);
    x_inc     = x + XW'(1);
    y_inc     = y + YW'(1);
    fc_inc    = frame_count + 8'd1;
  end

  assign bus.data        = data_q;
  assign bus.valid       = valid_q;
  assign bus.last        = last_q;
  assign bus.frame_start = frame_start_q;

  // The output registers always hold the pixel named by (x,y); each transfer
  // loads the following pixel so a continuously ready sink sees no bubbles.
  // 'armed' keeps valid low on the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      armed         <= 1'b0;
      x             <= '0;
      y             <= '0;
      pat           <= 2'd0;
      frame_count   <= 8'd0;
      data_q        <= 12'h000;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && enable) begin
            state         <= STREAM;
            pat           <= pattern_sel;
            x             <= '0;
            y             <= '0;
            valid_q       <= 1'b1;
            frame_start_q <= 1'b1;
            last_q        <= ONE_PIXEL_LINE;
            data_q        <= pixel('0, 1'b0, pattern_sel, frame_count[5:0]);
          end
        end
        STREAM: begin
          if (xfer) begin
            if (end_frame) begin
              frame_count <= fc_inc;
              x           <= '0;
              y           <= '0;
              if (!enable) begin
                state         <= IDLE;
                valid_q       <= 1'b0;
                frame_start_q <= 1'b0;
                last_q        <= 1'b0;
                data_q        <= 12'h000;
              end else begin
                pat           <= pattern_sel;
                frame_start_q <= 1'b1;
                last_q        <= ONE_PIXEL_LINE;
                data_q        <= pixel('0, 1'b0, pattern_sel, fc_inc[5:0]);
              end
            end else if (end_line) begin
              x             <= '0;
              y             <= y_inc;
              frame_start_q <= 1'b0;
              last_q        <= ONE_PIXEL_LINE;
              data_q        <= pixel('0, y_inc[5], pat, frame_count[5:0]);
            end else begin
              x             <= x_inc;
              frame_start_q <= 1'b0;
              last_q        <= (x_inc == X_LAST);
              data_q        <= pixel(x_inc, y[5], pat, frame_count[5:0]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pattern_source.sv
// Directed bench: a 640x2 instance for bars/grey/moving-bar/enable/reset cases,
// and a 64x40 instance for the checker pattern under toggling ready.
module tb_vga_pattern_source;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_a, en_b;
  logic [1:0] sel_a, sel_b;
  logic [7:0] fc_a, fc_b;

  vga_pattern_source_if if_a ();
  vga_pattern_source_if if_b ();

  vga_pattern_source #(.H_ACTIVE(640), .V_ACTIVE(2)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .enable      (en_a),
    .pattern_sel (sel_a),
    .bus         (if_a),
    .frame_count (fc_a)
  );

  vga_pattern_source #(.H_ACTIVE(64), .V_ACTIVE(40)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .enable      (en_b),
    .pattern_sel (sel_b),
    .bus         (if_b),
    .frame_count (fc_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int ax = 0, ay = 0, bx = 0, by = 0;
  int b_xfers = 0, b_hold_errs = 0, b_flag_errs = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // One clock: drive ready, advance the bench's own pixel positions on
  // transfers, and watch dut_b for held outputs and misplaced last/frame_start.
  task automatic applyStimulus(input logic rdy_a, input logic rdy_b);
    logic        xa, xb, hold, hl, hf;
    logic [11:0] hd;
    if_a.ready = rdy_a;
    if_b.ready = rdy_b;
    xa = if_a.valid && rdy_a;
    xb = if_b.valid && rdy_b;
    if (if_b.valid) begin
      if (if_b.last !== (bx == 63)) b_flag_errs++;
      if (if_b.frame_start !== (bx == 0 && by == 0)) b_flag_errs++;
    end
    hold = if_b.valid && !rdy_b;
    hd   = if_b.data;
    hl   = if_b.last;
    hf   = if_b.frame_start;
    @(posedge clk);
    #1;
    if (hold && (if_b.valid !== 1'b1 || if_b.data !== hd ||
                 if_b.last !== hl || if_b.frame_start !== hf)) b_hold_errs++;
    if (xa) begin
      if (ax == 639) begin ax = 0; ay = (ay == 1) ? 0 : 1; end
      else ax++;
    end
    if (xb) begin
      b_xfers++;
      if (bx == 63) begin bx = 0; by = (by == 39) ? 0 : by + 1; end
      else bx++;
    end
  endtask

  task automatic runToA(input int tx, input int ty);
    int budget;
    budget = 0;
    while (!(if_a.valid && ax == tx && ay == ty) && budget < 5000) begin
      applyStimulus(1'b1, 1'b0);
      budget++;
    end
    checkOutput($sformatf("reach_a_%0d_%0d", tx, ty), 32'(budget < 5000), 32'd1);
  endtask

  task automatic waitValidA();
    int budget;
    budget = 0;
    while (!if_a.valid && budget < 20) begin
      applyStimulus(1'b1, 1'b0);
      budget++;
    end
    checkOutput("valid_a_wait", 32'(if_a.valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v_32_0, v_32_32, v_0_0;
    logic        seen_valid, done;
    int          cyc;

    reset = 1'b1; en_a = 1'b0; en_b = 1'b0; sel_a = 2'd0; sel_b = 2'd0;
    if_a.ready = 1'b0; if_b.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(if_a.valid), 32'd0);
    checkOutput("rst_data", 32'(if_a.data), 32'h000);
    checkOutput("rst_last", 32'(if_a.last), 32'd0);
    checkOutput("rst_fs", 32'(if_a.frame_start), 32'd0);
    checkOutput("rst_fc", 32'(fc_a), 32'd0);

    // Release reset with enable already high: no valid on the first edge.
    en_a = 1'b1; if_a.ready = 1'b1; reset = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("no_valid_first_edge", 32'(if_a.valid), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("valid_after_enable", 32'(if_a.valid), 32'd1);
    checkOutput("bars_x0_data", 32'(if_a.data), 32'hFFF);
    checkOutput("bars_x0_fs", 32'(if_a.frame_start), 32'd1);
    checkOutput("bars_x0_last", 32'(if_a.last), 32'd0);
    runToA(80, 0);
    checkOutput("bars_x80_data", 32'(if_a.data), 32'hFF0);
    checkOutput("bars_x80_fs", 32'(if_a.frame_start), 32'd0);
    runToA(639, 0);
    checkOutput("bars_x639_last", 32'(if_a.last), 32'd1);
    checkOutput("bars_x639_data", 32'(if_a.data), 32'h000);
    runToA(0, 1);
    checkOutput("line1_x0_last", 32'(if_a.last), 32'd0);
    checkOutput("line1_x0_fs", 32'(if_a.frame_start), 32'd0);
    checkOutput("line1_x0_data", 32'(if_a.data), 32'hFFF);

    // Pattern change mid-frame only takes effect at the next frame.
    sel_a = 2'd2;
    runToA(80, 1);
    checkOutput("bars_kept_mid_frame", 32'(if_a.data), 32'hFF0);
    runToA(639, 1);
    checkOutput("frame0_end_last", 32'(if_a.last), 32'd1);
    runToA(0, 0);
    checkOutput("frame1_fs", 32'(if_a.frame_start), 32'd1);
    checkOutput("frame1_fc", 32'(fc_a), 32'd1);
    checkOutput("grey_x0", 32'(if_a.data), 32'h000);
    runToA(32, 0);
    checkOutput("grey_x32", 32'(if_a.data), 32'h111);
    runToA(511, 0);
    checkOutput("grey_x511", 32'(if_a.data), 32'hFFF);
    runToA(512, 0);
    checkOutput("grey_x512", 32'(if_a.data), 32'h000);

    // Dropping enable mid-frame lets the frame finish, then goes idle.
    en_a = 1'b0;
    runToA(639, 1);
    checkOutput("still_streaming", 32'(if_a.valid), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("idle_after_final", 32'(if_a.valid), 32'd0);
    checkOutput("fc_after_stop", 32'(fc_a), 32'd2);
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("idle_stays", 32'(if_a.valid), 32'd0);

    // Moving bar: frame_count 2 puts the red bar at x=32..47.
    sel_a = 2'd3; en_a = 1'b1;
    waitValidA();
    checkOutput("mbar_fs", 32'(if_a.frame_start), 32'd1);
    checkOutput("mbar_fc", 32'(fc_a), 32'd2);
    checkOutput("mbar_x0", 32'(if_a.data), 32'h00F);
    runToA(16, 0);
    checkOutput("mbar_x16", 32'(if_a.data), 32'h00F);
    runToA(32, 0);
    checkOutput("mbar_x32", 32'(if_a.data), 32'hF00);
    runToA(47, 0);
    checkOutput("mbar_x47", 32'(if_a.data), 32'hF00);
    runToA(48, 0);
    checkOutput("mbar_x48", 32'(if_a.data), 32'h00F);
    runToA(0, 0);
    checkOutput("mbar_fc3", 32'(fc_a), 32'd3);
    runToA(48, 0);
    checkOutput("mbar_fc3_x48", 32'(if_a.data), 32'hF00);

    // Asynchronous reset in the middle of a line.
    runToA(100, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(if_a.valid), 32'd0);
    checkOutput("arst_data", 32'(if_a.data), 32'h000);
    checkOutput("arst_last", 32'(if_a.last), 32'd0);
    checkOutput("arst_fc", 32'(fc_a), 32'd0);
    ax = 0; ay = 0; sel_a = 2'd0;
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("arst_no_valid_first_edge", 32'(if_a.valid), 32'd0);
    waitValidA();
    checkOutput("arst_restart_fs", 32'(if_a.frame_start), 32'd1);
    checkOutput("arst_restart_fc", 32'(fc_a), 32'd0);
    checkOutput("arst_restart_data", 32'(if_a.data), 32'hFFF);

    // Checker on dut_b with ready toggling every cycle; enable drops mid-frame.
    v_32_0 = 32'hDEAD; v_32_32 = 32'hDEAD; v_0_0 = 32'hDEAD;
    seen_valid = 1'b0; done = 1'b0; cyc = 0;
    sel_b = 2'd1; en_b = 1'b1;
    while (!done && cyc < 8000) begin
      if (if_b.valid) begin
        seen_valid = 1'b1;
        if (bx == 0 && by == 0) v_0_0 = 32'(if_b.data);
        if (bx == 32 && by == 0) v_32_0 = 32'(if_b.data);
        if (bx == 32 && by == 32) v_32_32 = 32'(if_b.data);
        if (by == 5) en_b = 1'b0;
      end else if (seen_valid) begin
        done = 1'b1;
      end
      if (!done) applyStimulus(1'b1, (cyc % 2) == 0);
      cyc++;
    end
    checkOutput("chk_completed", 32'(done), 32'd1);
    checkOutput("chk_xfers", 32'(b_xfers), 32'd2560);
    checkOutput("chk_fc", 32'(fc_b), 32'd1);
    checkOutput("chk_x0_y0", v_0_0, 32'h000);
    checkOutput("chk_x32_y0", v_32_0, 32'hFFF);
    checkOutput("chk_x32_y32", v_32_32, 32'h000);
    checkOutput("chk_hold_errs", 32'(b_hold_errs), 32'd0);
    checkOutput("chk_flag_errs", 32'(b_flag_errs), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
